// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one pipelined fp32 adder between NUM_REQ requesters.
// A tag FIFO records the requester of every issued operation so each result is
// steered back to its originator in issue order.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_a/i_req_b   requester side (operands packed 32 bits each)
//   o_rsp_valid/i_rsp_ready, o_rsp_result      response side (result broadcast)
//   o_add_a/o_add_b/o_add_valid/i_add_ready    adder input handshake
//   i_add_result/i_add_valid/o_add_ready       adder output handshake
//   o_outstanding        operations in flight (tag FIFO occupancy)
//   o_err                sticky: adder produced a result with no tag outstanding
module fp32_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*32-1:0]      i_req_a,
  input  logic [NUM_REQ*32-1:0]      i_req_b,
  output logic [NUM_REQ-1:0]         o_rsp_valid,
  input  logic [NUM_REQ-1:0]         i_rsp_ready,
  output logic [31:0]                o_rsp_result,
  output logic [31:0]                o_add_a,
  output logic [31:0]                o_add_b,
  output logic                       o_add_valid,
  input  logic                       i_add_ready,
  input  logic [31:0]                i_add_result,
  input  logic                       i_add_valid,
  output logic                       o_add_ready,
  output logic [$clog2(MAX_OUT):0]   o_outstanding,
  output logic                       o_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_OUT);

  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  tag_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             err_q;

  logic [ID_W-1:0]  gnt_id, cand, head, rr_next;
  logic             has_gnt, fifo_full, fifo_empty, issue, pop;

  // Rotating priority search starting at rr_ptr_q; the first hit wins.
  always_comb begin
    gnt_id  = '0;
    has_gnt = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!has_gnt && i_req_valid[cand]) begin
        has_gnt = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign rr_next    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign fifo_full  = (count_q == (PTR_W + 1)'(MAX_OUT));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];

  // Full blocks issue even if a pop frees a slot this cycle: keeps issue off the pop path.
  assign o_add_valid = has_gnt & ~fifo_full;
  assign o_add_a     = i_req_a[32*gnt_id +: 32];
  assign o_add_b     = i_req_b[32*gnt_id +: 32];
  assign issue       = o_add_valid & i_add_ready;
  assign o_req_ready = issue ? (NUM_REQ'(1) << gnt_id) : '0;

  // Only the head tag may drain; a stalled head blocks all later results.
  assign o_rsp_valid   = (i_add_valid && !fifo_empty) ? (NUM_REQ'(1) << head) : '0;
  assign o_rsp_result  = i_add_result;
  assign o_add_ready   = ~fifo_empty & i_rsp_ready[head];
  assign pop           = i_add_valid & o_add_ready;
  assign o_outstanding = count_q;
  assign o_err         = err_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) tag_q[i] <= '0;
    end else begin
      if (issue) begin
        tag_q[wr_ptr_q] <= gnt_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        rr_ptr_q        <= rr_next;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (issue && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !issue) count_q <= count_q - 1'b1;
      if (i_add_valid && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/fp32_add_arbiter.md
Name: fp32_add_arbiter

Overview:
- Shares one pipelined 2-stage fp32 adder (valid/ready on both sides) between NUM_REQ requesters.
- Arbitration is round-robin.
- A tag FIFO records the requester ID of every operation issued to the adder. Each result is steered back to its originator in issue order.
- Sits between the vector/accumulate engines and the single shared fp32 adder in the NPU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUT, 4, maximum operations in flight inside the adder; this is the tag FIFO depth (power of 2, >= 2).
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridable).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_req_valid  in  NUM_REQ  per-requester operation valid.
- o_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- i_req_a  in  NUM_REQ*32  operand A; requester k uses bits [32k+31:32k].
- i_req_b  in  NUM_REQ*32  operand B; same packing as i_req_a.
- o_rsp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
- i_rsp_ready  in  NUM_REQ  per-requester result accept.
- o_rsp_result  out  32  result, broadcast to all requesters.
- o_add_a  out  32  operand A to the adder.
- o_add_b  out  32  operand B to the adder.
- o_add_valid  out  1  adder input valid.
- i_add_ready  in  1  adder input ready.
- i_add_result  in  32  adder result.
- i_add_valid  in  1  adder output valid.
- o_add_ready  out  1  adder output ready.
- o_outstanding  out  $clog2(MAX_OUT)+1  count of operations in flight.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset (i_reset=1 at a rising edge):
  - rr_ptr=0, tag FIFO empty, o_outstanding=0, o_err=0.
  - Every output defined by the combinational rules below evaluates to 0 in this state, except o_add_a and o_add_b (don't-care when o_add_valid=0).
  - Reset mid-operation discards all tags. The adder must be reset in the same cycle; results already inside it are lost.
- Grant (combinational):
  - Search i_req_valid from index rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - The first set bit is gnt (ID gnt_id); has_gnt = |i_req_valid.
- Issue:
  - o_add_valid = has_gnt & ~fifo_full.
  - o_add_a and o_add_b are muxed from requester gnt_id.
  - o_req_ready[gnt_id] = o_add_valid & i_add_ready; all other bits are 0.
  - issue = o_add_valid & i_add_ready. On issue: push gnt_id into the tag FIFO and set rr_ptr = (gnt_id+1) mod NUM_REQ.
  - rr_ptr is unchanged on cycles with no issue.
- Requester rules: once i_req_valid is asserted, the requester holds valid and operands stable until it sees ready. The grant therefore only moves when an issue occurs.
- Full: when the FIFO holds MAX_OUT tags, o_add_valid=0 even if a pop happens in the same cycle. No push is allowed on full.
- Response (combinational):
  - head = the FIFO head ID.
  - o_rsp_valid[head] = i_add_valid & ~fifo_empty; all other bits are 0.
  - o_rsp_result = i_add_result.
  - o_add_ready = ~fifo_empty & i_rsp_ready[head]. A stalled head requester blocks every later result (in-order).
  - pop = i_add_valid & o_add_ready.
- Simultaneous push and pop:
  - Legal when not full; the count is unchanged.
  - On empty, push only; a result can never bypass its own tag.
- Error: i_add_valid=1 while the FIFO is empty sets o_err=1. o_err stays set until reset; o_add_ready stays 0 in that case.
- Accounting:
  - o_outstanding equals the FIFO occupancy: +1 per issue, -1 per pop.
  - It is registered and updates at the clock edge after the event.
- Latency: zero added cycles in both directions. End-to-end latency equals the adder latency (2 cycles) plus any stalls.
- Wrap: FIFO read and write pointers wrap modulo MAX_OUT; a separate count distinguishes full from empty.

Test Plan:
- Single op: requester 2 sends a=0x3F800000, b=0x40000000 with i_add_ready=1 → o_req_ready=0100 that cycle. Two cycles later o_rsp_valid=0100 and o_rsp_result=0x40400000; o_outstanding goes 1 then 0.
- Round-robin: all 4 requesters valid continuously, adder always ready → grants are 0,1,2,3,0,1 in consecutive cycles. Each requester receives its own sum, e.g. k+1.0 + 1.0.
- Back-pressure: i_rsp_ready[0]=0 while requesters 0 and 1 have results in flight → o_add_ready=0 and requester 1 gets no result. After i_rsp_ready[0]=1, both results are delivered in order on consecutive cycles.
- Full: hold i_rsp_ready=0 and issue 4 ops → o_outstanding=4 and o_add_valid=0 with requests pending. One pop frees a slot, and the next issue occurs one cycle later.
- Reset mid-flight: i_reset asserted with 3 ops outstanding → next cycle o_outstanding=0, all valid outputs 0, and rr_ptr=0 (requester 0 wins the next grant).
- Error: drive i_add_valid=1 with the FIFO empty → o_err=1 and o_rsp_valid=0. o_err stays 1 until i_reset.
